// File: rtl/psum_lane_collector_if.sv
// psum_lane_collector_if
// Stream bundle between a partial-sum producer and psum_lane_collector, and
// between the collector and the downstream masked-lane serial adder.
//   in_valid/in_ready/in_idx/in_data/in_last : per-lane write stream
//   out_valid/out_ready/ctr/data_out         : packed group handoff
//   err_idx                                  : sticky bad-lane-index flag
// The slave modport is the collector's view; master is the surrounding system.
interface psum_lane_collector_if #(
   parameter int NUM      = 4,
   parameter int bitwidth = 16
);
   localparam int IDXW = (NUM > 1) ? $clog2(NUM) : 1;

   logic                    in_valid;
   logic                    in_ready;
   logic [IDXW-1:0]         in_idx;
   logic [bitwidth-1:0]     in_data;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic [NUM-1:0]          ctr;
   logic [NUM*bitwidth-1:0] data_out;
   logic                    err_idx;

   modport slave (
      input  in_valid, in_idx, in_data, in_last, out_ready,
      output in_ready, out_valid, ctr, data_out, err_idx
   );

   modport master (
      output in_valid, in_idx, in_data, in_last, out_ready,
      input  in_ready, out_valid, ctr, data_out, err_idx
   );
endinterface

// File: rtl/psum_lane_collector.sv
// psum_lane_collector
// Gathers per-lane partial sums (one per cycle) into a NUM-lane buffer and
// presents the packed vector plus its lane-valid mask in the ctr/data_out
// format of the serial adder. A repeated write to a lane accumulates (wrapping).
// A group closes on in_last or once every lane has been written.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : psum_lane_collector_if.slave (write stream, group handoff, err_idx)
module psum_lane_collector #(
   parameter int NUM      = 4,
   parameter int bitwidth = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   psum_lane_collector_if.slave  bus
);
   localparam int IDXW = (NUM > 1) ? $clog2(NUM) : 1;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [NUM-1:0]          ctr_r;
   logic [NUM-1:0]          ctr_nxt_s;
   logic [NUM*bitwidth-1:0] data_r;
   logic [NUM*bitwidth-1:0] data_nxt_s;
   logic                    err_r;
   logic                    err_nxt_s;
   logic                    out_valid_r;
   logic                    accept_s;
   logic [NUM-1:0]          lane_sel_s;
   logic                    idx_ok_s;

   // Writes are taken only while collecting; ready depends on state alone.
   assign bus.in_ready  = (state_r == COLLECT);
   assign bus.out_valid = out_valid_r;
   assign bus.ctr       = ctr_r;
   assign bus.data_out  = data_r;
   assign bus.err_idx   = err_r;

   // Decode the target lane; an index matching no lane is out of range.
   always_comb begin
      accept_s   = bus.in_valid & (state_r == COLLECT);
      lane_sel_s = {NUM{1'b0}};
      for (int i = 0; i < NUM; i++) begin
         lane_sel_s[i] = (bus.in_idx == IDXW'(i));
      end
      idx_ok_s = |lane_sel_s;
   end

   // Next-state and buffer update: write/accumulate in COLLECT, clear on handoff.
   always_comb begin
      state_nxt_s = state_r;
      ctr_nxt_s   = ctr_r;
      data_nxt_s  = data_r;
      err_nxt_s   = err_r;
      case (state_r)
         COLLECT: begin
            if (accept_s) begin
               for (int i = 0; i < NUM; i++) begin
                  if (lane_sel_s[i]) begin
                     // First write loads the lane, later ones accumulate mod 2^bitwidth.
                     if (ctr_r[i]) begin
                        data_nxt_s[i*bitwidth +: bitwidth] =
                           data_r[i*bitwidth +: bitwidth] + bus.in_data;
                     end else begin
                        data_nxt_s[i*bitwidth +: bitwidth] = bus.in_data;
                     end
                     ctr_nxt_s[i] = 1'b1;
                  end else begin
                     ctr_nxt_s[i] = ctr_r[i];
                  end
               end
               if (!idx_ok_s) begin
                  err_nxt_s = 1'b1;
               end else begin
                  err_nxt_s = err_r;
               end
               // Close on explicit last or when this write completes the mask.
               if (bus.in_last || (&ctr_nxt_s)) begin
                  state_nxt_s = HOLD;
               end else begin
                  state_nxt_s = COLLECT;
               end
            end else begin
               state_nxt_s = COLLECT;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_nxt_s = COLLECT;
               ctr_nxt_s   = {NUM{1'b0}};
               data_nxt_s  = {(NUM*bitwidth){1'b0}};
            end else begin
               state_nxt_s = HOLD;
            end
         end
         default: begin
            state_nxt_s = COLLECT;
         end
      endcase
   end

   // State and buffer registers; out_valid is registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= COLLECT;
         ctr_r       <= {NUM{1'b0}};
         data_r      <= {(NUM*bitwidth){1'b0}};
         err_r       <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         ctr_r       <= ctr_nxt_s;
         data_r      <= data_nxt_s;
         err_r       <= err_nxt_s;
         out_valid_r <= (state_nxt_s == HOLD);
      end
   end
endmodule

// File: tb/tb_psum_lane_collector.sv
// tb_psum_lane_collector
// Directed bench: a NUM=4 instance for the main write/accumulate/close/
// backpressure behaviour, and a NUM=3 instance for the out-of-range index
// and asynchronous reset behaviour. Expected values are hand-computed.
module tb_psum_lane_collector;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   psum_lane_collector_if #(.NUM(4), .bitwidth(16)) a_if ();
   psum_lane_collector_if #(.NUM(3), .bitwidth(16)) b_if ();

   psum_lane_collector #(.NUM(4), .bitwidth(16)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if.slave)
   );

   psum_lane_collector #(.NUM(3), .bitwidth(16)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_drive(input logic v, input logic [1:0] idx, input logic [15:0] d, input logic last);
      a_if.in_valid = v;
      a_if.in_idx   = idx;
      a_if.in_data  = d;
      a_if.in_last  = last;
   endtask

   task automatic b_drive(input logic v, input logic [1:0] idx, input logic [15:0] d, input logic last);
      b_if.in_valid = v;
      b_if.in_idx   = idx;
      b_if.in_data  = d;
      b_if.in_last  = last;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      a_drive(1'b1, 2'd1, 16'h1234, 1'b0);
      a_if.out_ready = 1'b0;
      b_drive(1'b0, 2'd0, 16'h0000, 1'b0);
      b_if.out_ready = 1'b0;

      // Reset state, with a write request pending that must be ignored
      tick();
      tick();
      chk("rst_out_valid", a_if.out_valid, 64'd0);
      chk("rst_in_ready",  a_if.in_ready,  64'd1);
      chk("rst_ctr",       a_if.ctr,       64'd0);
      chk("rst_data",      a_if.data_out,  64'd0);
      chk("rst_err",       a_if.err_idx,   64'd0);
      a_drive(1'b0, 2'd0, 16'h0000, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Sparse group closed by last
      tick();
      a_drive(1'b1, 2'd0, 16'd5, 1'b0);
      tick();
      chk("t1_ctr_after_w0",  a_if.ctr,       64'h1);
      chk("t1_data_after_w0", a_if.data_out,  64'h0000_0000_0000_0005);
      chk("t1_ovalid_open",   a_if.out_valid, 64'd0);
      a_drive(1'b1, 2'd2, 16'd7, 1'b1);
      tick();
      chk("t1_out_valid",     a_if.out_valid, 64'd1);
      chk("t1_in_ready",      a_if.in_ready,  64'd0);
      chk("t1_ctr",           a_if.ctr,       64'h5);
      chk("t1_data",          a_if.data_out,  64'h0000_0007_0000_0005);
      a_drive(1'b0, 2'd0, 16'd0, 1'b0);
      a_if.out_ready = 1'b1;
      tick();
      chk("t1_clr_valid",     a_if.out_valid, 64'd0);
      chk("t1_clr_ctr",       a_if.ctr,       64'd0);
      chk("t1_clr_data",      a_if.data_out,  64'd0);
      chk("t1_clr_ready",     a_if.in_ready,  64'd1);
      a_if.out_ready = 1'b0;

      // Full mask closes without last
      for (int i = 0; i < 4; i++) begin
         a_drive(1'b1, 2'(i), 16'(i + 1), 1'b0);
         tick();
      end
      a_drive(1'b0, 2'd0, 16'd0, 1'b0);
      chk("t2_out_valid",     a_if.out_valid, 64'd1);
      chk("t2_ctr",           a_if.ctr,       64'hF);
      chk("t2_data",          a_if.data_out,  64'h0004_0003_0002_0001);
      tick();
      chk("t2_in_ready",      a_if.in_ready,  64'd0);
      a_if.out_ready = 1'b1;
      tick();
      a_if.out_ready = 1'b0;
      chk("t2_clr_valid",     a_if.out_valid, 64'd0);

      // Duplicate write accumulates with wrap
      a_drive(1'b1, 2'd1, 16'hFFFF, 1'b0);
      tick();
      a_drive(1'b1, 2'd1, 16'h0003, 1'b1);
      tick();
      a_drive(1'b0, 2'd0, 16'd0, 1'b0);
      chk("t3_out_valid",     a_if.out_valid, 64'd1);
      chk("t3_ctr",           a_if.ctr,       64'h2);
      chk("t3_data",          a_if.data_out,  64'h0000_0000_0002_0000);
      a_if.out_ready = 1'b1;
      tick();
      a_if.out_ready = 1'b0;

      // Backpressure: pending write held off while the group is presented
      a_drive(1'b1, 2'd3, 16'h000A, 1'b1);
      tick();
      a_drive(1'b1, 2'd0, 16'h0055, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_hold_ready",  a_if.in_ready,  64'd0);
         chk("t4_hold_valid",  a_if.out_valid, 64'd1);
         chk("t4_hold_ctr",    a_if.ctr,       64'h8);
         chk("t4_hold_data",   a_if.data_out,  64'h000A_0000_0000_0000);
      end
      a_if.out_ready = 1'b1;
      tick();
      a_if.out_ready = 1'b0;
      chk("t4_handoff_valid", a_if.out_valid, 64'd0);
      chk("t4_handoff_ready", a_if.in_ready,  64'd1);
      chk("t4_handoff_ctr",   a_if.ctr,       64'd0);
      chk("t4_handoff_data",  a_if.data_out,  64'd0);
      tick();
      a_drive(1'b0, 2'd0, 16'd0, 1'b0);
      chk("t4_pending_ctr",   a_if.ctr,       64'h1);
      chk("t4_pending_data",  a_if.data_out,  64'h0000_0000_0000_0055);
      // out_ready while collecting has no effect
      a_if.out_ready = 1'b1;
      tick();
      a_if.out_ready = 1'b0;
      chk("t4_ordy_ignored",  a_if.ctr,       64'h1);
      a_drive(1'b1, 2'd0, 16'h0001, 1'b1);
      tick();
      a_drive(1'b0, 2'd0, 16'd0, 1'b0);
      chk("t4_acc_data",      a_if.data_out,  64'h0000_0000_0000_0056);
      chk("t4_acc_valid",     a_if.out_valid, 64'd1);
      chk("a_err_clean",      a_if.err_idx,   64'd0);

      // NUM=3: out-of-range index with last
      b_drive(1'b1, 2'd3, 16'h0009, 1'b1);
      tick();
      b_drive(1'b0, 2'd0, 16'd0, 1'b0);
      chk("b_err_set",        b_if.err_idx,   64'd1);
      chk("b_bad_valid",      b_if.out_valid, 64'd1);
      chk("b_bad_ctr",        b_if.ctr,       64'd0);
      chk("b_bad_data",       b_if.data_out,  64'd0);
      b_if.out_ready = 1'b1;
      tick();
      b_if.out_ready = 1'b0;
      chk("b_err_sticky",     b_if.err_idx,   64'd1);
      chk("b_bad_clr_valid",  b_if.out_valid, 64'd0);
      b_drive(1'b1, 2'd2, 16'h0033, 1'b0);
      tick();
      b_drive(1'b0, 2'd0, 16'd0, 1'b0);
      chk("b_part_ctr",       b_if.ctr,       64'h4);
      chk("b_part_data",      b_if.data_out,  64'h0033_0000_0000);

      // Asynchronous reset mid-group takes effect between edges
      #2;
      rst = 1'b1;
      #1;
      chk("b_arst_ctr",       b_if.ctr,       64'd0);
      chk("b_arst_data",      b_if.data_out,  64'd0);
      chk("b_arst_err",       b_if.err_idx,   64'd0);
      chk("b_arst_valid",     b_if.out_valid, 64'd0);
      chk("b_arst_ready",     b_if.in_ready,  64'd1);
      chk("a_arst_valid",     a_if.out_valid, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      b_drive(1'b1, 2'd0, 16'h0011, 1'b1);
      tick();
      b_drive(1'b0, 2'd0, 16'd0, 1'b0);
      chk("b_new_ctr",        b_if.ctr,       64'h1);
      chk("b_new_data",       b_if.data_out,  64'h0000_0000_0011);
      chk("b_new_valid",      b_if.out_valid, 64'd1);
      chk("b_new_err",        b_if.err_idx,   64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
